// File: rtl/bcd_pkg.sv
// Shared constants and types for the serial BCD collector and its 7-segment decoder.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Segment patterns are {g,f,e,d,c,b,a}, active-high; blank is all segments off.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Bit position within the current digit; S3 is the capture slot.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } bit_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show blank.
module bcd_to_7seg
    import bcd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Map each decimal value to its active-high segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_serial_collector.sv
// Deserialises an LSB-first serial BCD stream into digits, validates them,
// keeps a history of recent valid digits and drives a 7-segment pattern.
// Digit framing is purely reset-aligned: the first edge after reset is bit 0.
module bcd_serial_collector
    import bcd_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
)(
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Z,
    output logic                       DigitValid,
    output logic                       DigitErr,
    output logic [3:0]                 Digit,
    output logic [4*NDIG-1:0]          History,
    output logic [$clog2(NDIG+1)-1:0]  Count,
    output logic [7:0]                 ErrCount,
    output logic [6:0]                 Seg
);

    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(NDIG);
    localparam logic [6:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    bit_state_t        bit_state;
    logic [2:0]        sh;
    logic [3:0]        captured;
    logic [4*NDIG-1:0] hist_shift;
    logic [6:0]        seg_raw;

    assign captured = {Z, sh};

    bcd_to_7seg u_dec (
        .bcd (captured),
        .seg (seg_raw)
    );

    // Next history value: age every nibble by one slot and insert the new digit at the bottom.
    always_comb begin
        hist_shift = History << DIGIT_W;
        hist_shift[DIGIT_W-1:0] = captured;
    end

    // Bit-counter FSM with capture, history, counters and registered segment output.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bit_state  <= S0;
            sh         <= '0;
            Digit      <= '0;
            History    <= '0;
            Count      <= '0;
            ErrCount   <= '0;
            DigitValid <= 1'b0;
            DigitErr   <= 1'b0;
            Seg        <= SEG_BLANK ^ SEG_MASK;
        end else begin
            DigitValid <= 1'b0;
            DigitErr   <= 1'b0;
            case (bit_state)
                S0: begin
                    sh[0]     <= Z;
                    bit_state <= S1;
                end
                S1: begin
                    sh[1]     <= Z;
                    bit_state <= S2;
                end
                S2: begin
                    sh[2]     <= Z;
                    bit_state <= S3;
                end
                S3: begin
                    bit_state <= S0;
                    Digit     <= captured;
                    if (captured <= BCD_MAX) begin
                        DigitValid <= 1'b1;
                        History    <= hist_shift;
                        Seg        <= seg_raw ^ SEG_MASK;
                        if (Count != COUNT_MAX) begin
                            Count <= Count + 1'b1;
                        end
                    end else begin
                        DigitErr <= 1'b1;
                        if (ErrCount != 8'hFF) begin
                            ErrCount <= ErrCount + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_collector.sv
// Scoreboard bench for bcd_serial_collector: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a strobe appears.
module tb_bcd_serial_collector;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
        logic [15:0] hist;
        logic [2:0] count;
        logic [7:0] errc;
        logic [6:0] seg;
    } exp_t;

    logic        Clk;
    logic        Rst;
    logic        Z;
    logic        digit_valid, digit_err;
    logic [3:0]  digit;
    logic [15:0] history;
    logic [2:0]  count;
    logic [7:0]  err_count;
    logic [6:0]  seg;
    logic        al_valid, al_err;
    logic [3:0]  al_digit;
    logic [15:0] al_history;
    logic [2:0]  al_count;
    logic [7:0]  al_err_count;
    logic [6:0]  al_seg;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    exp_t sb[$];

    logic [15:0] m_hist;
    logic [2:0]  m_count;
    logic [7:0]  m_err;
    logic [6:0]  m_seg;

    bcd_serial_collector #(.NDIG(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Z          (Z),
        .DigitValid (digit_valid),
        .DigitErr   (digit_err),
        .Digit      (digit),
        .History    (history),
        .Count      (count),
        .ErrCount   (err_count),
        .Seg        (seg)
    );

    bcd_serial_collector #(.NDIG(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .Clk        (Clk),
        .Rst        (Rst),
        .Z          (Z),
        .DigitValid (al_valid),
        .DigitErr   (al_err),
        .Digit      (al_digit),
        .History    (al_history),
        .Count      (al_count),
        .ErrCount   (al_err_count),
        .Seg        (al_seg)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] expSeg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Serially drive one digit LSB first; after the capture edge push the model's expectation.
    task automatic applyStimulus(input logic [3:0] d);
        for (int i = 0; i < 4; i++) begin
            Z = d[i];
            @(posedge Clk);
            if (i == 3) begin
                if (d <= 4'd9) begin
                    m_hist = {m_hist[11:0], d};
                    if (m_count != 3'd4) m_count = m_count + 3'd1;
                    m_seg = expSeg(d);
                    sb.push_back('{1'b1, d, m_hist, m_count, m_err, m_seg});
                end else begin
                    if (m_err != 8'hFF) m_err = m_err + 8'd1;
                    sb.push_back('{1'b0, d, m_hist, m_count, m_err, m_seg});
                end
            end
            @(negedge Clk);
        end
    endtask

    // Drive a partial digit of k bits without any capture.
    task automatic applyPartial(input logic [3:0] d, input int k);
        for (int i = 0; i < k; i++) begin
            Z = d[i];
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

    // Assert reset away from clock edges, check immediate clearing, release on a negedge.
    task automatic doReset();
        #2;
        Rst = 1'b0;
        #1;
        checkOutput("rst_digit", {28'd0, digit}, 32'd0);
        checkOutput("rst_history", {16'd0, history}, 32'd0);
        checkOutput("rst_count", {29'd0, count}, 32'd0);
        checkOutput("rst_errcount", {24'd0, err_count}, 32'd0);
        checkOutput("rst_strobes", {30'd0, digit_valid, digit_err}, 32'd0);
        checkOutput("rst_seg", {25'd0, seg}, 32'h00);
        checkOutput("rst_seg_al", {25'd0, al_seg}, 32'h7F);
        m_hist  = '0;
        m_count = '0;
        m_err   = '0;
        m_seg   = 7'h00;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    // Monitor: on any strobe, pop the next expectation and compare all outputs of both instances.
    always @(negedge Clk) begin
        exp_t e;
        if (digit_valid || digit_err) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_strobe actual=valid%0b/err%0b required=none", digit_valid, digit_err);
            end else begin
                e = sb.pop_front();
                checkOutput("valid", {31'd0, digit_valid}, {31'd0, e.valid});
                checkOutput("err", {31'd0, digit_err}, {31'd0, ~e.valid});
                checkOutput("digit", {28'd0, digit}, {28'd0, e.digit});
                checkOutput("history", {16'd0, history}, {16'd0, e.hist});
                checkOutput("count", {29'd0, count}, {29'd0, e.count});
                checkOutput("errcount", {24'd0, err_count}, {24'd0, e.errc});
                checkOutput("seg", {25'd0, seg}, {25'd0, e.seg});
                checkOutput("al_seg", {25'd0, al_seg}, {25'd0, ~e.seg});
                checkOutput("al_strobes", {30'd0, al_valid, al_err}, {30'd0, e.valid, ~e.valid});
                checkOutput("al_state", {al_history, al_digit, al_count, 1'b0, al_err_count},
                            {e.hist, e.digit, e.count, 1'b0, e.errc});
            end
        end
    end

    initial begin
        Rst = 1'b0;
        Z   = 1'b0;
        m_hist = '0; m_count = '0; m_err = '0; m_seg = 7'h00;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        doReset();

        $display("[TB] single digit 5");
        applyStimulus(4'd5);
        checkOutput("d5_seg", {25'd0, seg}, 32'h6D);
        checkOutput("d5_count", {29'd0, count}, 32'd1);

        $display("[TB] history wrap");
        doReset();
        for (int i = 1; i <= 5; i++) applyStimulus(4'(i));
        checkOutput("wrap_history", {16'd0, history}, 32'h2345);
        checkOutput("wrap_count", {29'd0, count}, 32'd4);

        $display("[TB] invalid digit 10");
        applyStimulus(4'd10);
        checkOutput("err_errcount", {24'd0, err_count}, 32'd1);
        checkOutput("err_history", {16'd0, history}, 32'h2345);
        checkOutput("err_seg", {25'd0, seg}, 32'h6D);
        checkOutput("err_digit", {28'd0, digit}, 32'd10);

        $display("[TB] reset mid-digit then 9");
        applyPartial(4'b0001, 2);
        doReset();
        applyStimulus(4'd9);
        checkOutput("mid_seg", {25'd0, seg}, 32'h6F);
        checkOutput("mid_history", {16'd0, history}, 32'h0009);

        $display("[TB] active-low digit 8");
        applyStimulus(4'd8);
        checkOutput("al_seg8", {25'd0, al_seg}, 32'h00);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 260; i++) applyStimulus(4'(10 + (i % 6)));
        checkOutput("err_sat", {24'd0, err_count}, 32'd255);
        checkOutput("err_sat_history", {16'd0, history}, 32'h0098);

        $display("[TB] random stream with async resets");
        doReset();
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyPartial(4'($urandom_range(0, 9)), $urandom_range(1, 3));
                doReset();
            end
            applyStimulus(4'($urandom_range(0, 9)));
        end
        checkOutput("rand_errcount", {24'd0, err_count}, {24'd0, m_err});
        checkOutput("rand_history", {16'd0, history}, {16'd0, m_hist});

        @(negedge Clk);
        @(negedge Clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
